// File: rtl/output_stream_buffer.sv
// output_stream_buffer: collects LANES-wide capture beats into one OUT_H*OUT_W frame, then streams it out one element at a time.
// Optional: define OUTPUT_STREAM_BUFFER_RELU_EN to zero negative elements on output.
module output_stream_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int LANES = 9,
  parameter int OUT_H = 7,
  parameter int OUT_W = 7
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [31:0]                 out_data,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        frame_done,
  output logic                        overflow
);
  localparam int DEPTH = OUT_H * OUT_W;
  localparam int PW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + LANES + 1);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic frame_done_q, frame_done_d, overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] avail, n;
  logic cap, xfer, last;
  logic [DATA_WIDTH-1:0] elem;
  logic [31:0] ext;
  assign in_ready = state_q == FILL;
  assign out_valid = state_q == DRAIN;
  assign last = rd_ptr_q == PW'(DEPTH - 1);
  assign out_last = out_valid && last;
  assign cap = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign avail = CW'(DEPTH) - CW'(wr_ptr_q);
  assign n = (avail < CW'(LANES)) ? avail : CW'(LANES);
  assign elem = mem[rd_ptr_q];
  assign ext = 32'(signed'(elem));
  assign frame_done = frame_done_q;
  assign overflow = overflow_q;
`ifdef OUTPUT_STREAM_BUFFER_RELU_EN
  assign out_data = (out_valid && !elem[DATA_WIDTH-1]) ? ext : 32'h0;
`else
  assign out_data = out_valid ? ext : 32'h0;
`endif
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    frame_done_d = 1'b0;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (cap) begin
      wr_ptr_d = wr_ptr_q + PW'(n);
      state_d = (CW'(wr_ptr_q) + n == CW'(DEPTH)) ? DRAIN : FILL;
      rd_ptr_d = '0;
    end
    if (xfer) begin
      rd_ptr_d = last ? '0 : rd_ptr_q + PW'(1);
      state_d = last ? FILL : DRAIN;
      wr_ptr_d = last ? '0 : wr_ptr_q;
      frame_done_d = last;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      overflow_q <= overflow_d;
    end
  end
  // Storage is deliberately not reset; lanes past the end of the frame are dropped.
  always_ff @(posedge clk) begin
    if (cap)
      for (int i = 0; i < LANES; i++)
        if (CW'(i) < n) mem[wr_ptr_q + PW'(i)] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule
